// File: rtl/dpram_pkg.sv
// Shared defaults and width derivation for the packing FIFO and its RAM.
package dpram_pkg;

  localparam int unsigned DEF_IN_W  = 8;
  localparam int unsigned DEF_RATIO = 4;
  localparam int unsigned DEF_DEPTH = 16384;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned p = 1; p < value; p = p << 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/sdp_ram_sync.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module sdp_ram_sync #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset; the array stays reset-free for block RAM inference.
  always_ff @(posedge clk) begin
    if (!rst_n)  rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dpram_pack_fifo.sv
// Width-converting FIFO: packs RATIO beats per word into a dual-port RAM with show-ahead output.
// Optional partial-word flush enabled by defining DPRAM_PACK_FLUSH_EN.
module dpram_pack_fifo
  import dpram_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned RATIO = DEF_RATIO,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned OUT_W = IN_W * RATIO,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
`ifdef DPRAM_PACK_FLUSH_EN
  input  logic             flush,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam int unsigned LW   = clog2(RATIO);
  localparam logic [LW-1:0] LAST = LW'(RATIO - 1);

  logic [LW-1:0]    lane;
  logic [OUT_W-1:0] hold;
  logic [OUT_W-1:0] merged;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             out_valid_q;
  logic             accept;
  logic             last_beat;
  logic             wr;
  logic             rd_en;

  assign full      = (level_q == (AW+1)'(DEPTH));
  assign in_ready  = !((lane == LAST) && full);
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (lane == LAST);
  assign rd_en     = (!out_valid_q || out_ready) && (level_q != '0);

  // Upper lanes of hold are zero after every write, so merged doubles as the flushed word.
  always_comb begin
    merged = hold;
    if (accept) merged[lane*IN_W +: IN_W] = in_data;
  end

`ifdef DPRAM_PACK_FLUSH_EN
  logic flush_pend;
  logic flush_req;
  logic filled;
  logic flush_wr;

  assign flush_req = flush || flush_pend;
  assign filled    = (lane != '0) || accept;
  assign flush_wr  = flush_req && filled && !last_beat && !full;
  assign wr        = last_beat || flush_wr;

  // A flush that finds the RAM full waits here until a slot frees.
  always_ff @(posedge clk) begin
    if (!rst_n) flush_pend <= 1'b0;
    else        flush_pend <= flush_req && filled && !last_beat && full;
  end
`else
  assign wr = last_beat;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane        <= '0;
      hold        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (wr) begin
        lane   <= '0;
        hold   <= '0;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (accept) begin
        lane <= lane + 1'b1;
        hold <= merged;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd_en)      level_q <= level_q + 1'b1;
      else if (!wr && rd_en) level_q <= level_q - 1'b1;
      if (rd_en)          out_valid_q <= 1'b1;
      else if (out_ready) out_valid_q <= 1'b0;
    end
  end

  sdp_ram_sync #(
    .W  (OUT_W),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr),
    .wr_addr (wr_ptr),
    .wr_data (merged),
    .re      (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign empty     = (level_q == '0) && !out_valid_q;

endmodule
